// File: rtl/alu_exec_wb_if.sv
// Opcode encodings and the issue/CDB bundle shared by the ALU exec/writeback
// stage and whatever drives it (reservation station side and CDB arbiter).
package alu_exec_wb_pkg;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SLL   = 6'd3;
    localparam logic [5:0] OP_SRL   = 6'd4;
    localparam logic [5:0] OP_SRA   = 6'd5;
    localparam logic [5:0] OP_SLT   = 6'd6;
    localparam logic [5:0] OP_SLTU  = 6'd7;
    localparam logic [5:0] OP_XOR   = 6'd8;
    localparam logic [5:0] OP_OR    = 6'd9;
    localparam logic [5:0] OP_AND   = 6'd10;
    localparam logic [5:0] OP_LUI   = 6'd11;
    localparam logic [5:0] OP_AUIPC = 6'd12;
    localparam logic [5:0] OP_JAL   = 6'd13;
    localparam logic [5:0] OP_JALR  = 6'd14;
endpackage

interface alu_exec_wb_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int BTAG_W = 4,
    parameter int OP_W   = 6
);
    logic              rdy;
    logic              in_en;
    logic [DATA_W-1:0] in_op_a;
    logic [DATA_W-1:0] in_op_b;
    logic [OP_W-1:0]   in_op;
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_pc;
    logic [BTAG_W-1:0] in_btag;
    logic              in_ready;
    logic              b_free_en;
    logic [1:0]        b_free_num;
    logic              mis_taken;
    logic              cdb_req;
    logic              cdb_grant;
    logic              cdb_en;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              overflow;

    modport master (
        output rdy, in_en, in_op_a, in_op_b, in_op, in_tag, in_pc, in_btag,
               b_free_en, b_free_num, mis_taken, cdb_grant,
        input  in_ready, cdb_req, cdb_en, cdb_tag, cdb_data, overflow
    );

    modport slave (
        input  rdy, in_en, in_op_a, in_op_b, in_op, in_tag, in_pc, in_btag,
               b_free_en, b_free_num, mis_taken, cdb_grant,
        output in_ready, cdb_req, cdb_en, cdb_tag, cdb_data, overflow
    );
endinterface

// File: rtl/alu_exec_wb.sv
// ALU execute + writeback: computes the issued op into a small result queue and
// broadcasts on the CDB; branch masks let a mispredict squash queued results.
module alu_exec_wb #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int BTAG_W = 4,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 2
) (
    input logic          clk,
    input logic          rst,
    alu_exec_wb_if.slave bus
);
    import alu_exec_wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SH_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [BTAG_W-1:0] btag_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q;

    logic [DATA_W-1:0] result;
    logic [SH_W-1:0]   shamt;
    logic [BTAG_W-1:0] br_bit, in_btag_eff;
    logic              kill, clear, head_kill, in_kill, push, pop;

    assign shamt = bus.in_op_b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (bus.in_op)
            OP_ADD:   result = bus.in_op_a + bus.in_op_b;
            OP_SUB:   result = bus.in_op_a - bus.in_op_b;
            OP_SLL:   result = bus.in_op_a << shamt;
            OP_SRL:   result = bus.in_op_a >> shamt;
            OP_SRA:   result = $signed(bus.in_op_a) >>> shamt;
            OP_SLT:   result = {{(DATA_W-1){1'b0}}, $signed(bus.in_op_a) < $signed(bus.in_op_b)};
            OP_SLTU:  result = {{(DATA_W-1){1'b0}}, bus.in_op_a < bus.in_op_b};
            OP_XOR:   result = bus.in_op_a ^ bus.in_op_b;
            OP_OR:    result = bus.in_op_a | bus.in_op_b;
            OP_AND:   result = bus.in_op_a & bus.in_op_b;
            OP_LUI:   result = bus.in_op_b;
            OP_AUIPC: result = bus.in_pc + bus.in_op_b;
            OP_JAL,
            OP_JALR:  result = bus.in_pc + DATA_W'(4);
            default:  result = '0;
        endcase
    end

    // Squashed slots keep their place and are skipped at the head, so order is preserved.
    always_comb begin
        br_bit      = BTAG_W'(1) << bus.b_free_num;
        kill        = bus.rdy & bus.b_free_en & bus.mis_taken;
        clear       = bus.rdy & bus.b_free_en & ~bus.mis_taken;
        in_btag_eff = clear ? (bus.in_btag & ~br_bit) : bus.in_btag;
        head_kill   = kill & |(btag_q[head_q] & br_bit);
        in_kill     = kill & |(bus.in_btag & br_bit);

        // NOTE: a head squashed this cycle drops cdb_req combinationally, so a grant can't leak it.
        bus.cdb_req  = bus.rdy & valid_q[head_q] & ~head_kill;
        bus.cdb_en   = bus.cdb_req & bus.cdb_grant;
        bus.in_ready = (count_q < DEPTH_C);

        push = bus.rdy & bus.in_en & bus.in_ready & (bus.in_tag != '0) & ~in_kill;
        pop  = bus.rdy & (count_q != '0) & (bus.cdb_en | ~valid_q[head_q]);

        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill && (btag_q[i] & br_bit) != '0) valid_d[i] = 1'b0;
            if (pop && head_q == PTR_W'(i))         valid_d[i] = 1'b0;
            if (push && tail_q == PTR_W'(i))        valid_d[i] = 1'b1;
        end

        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    assign bus.cdb_tag  = bus.cdb_en ? tag_q[head_q]  : '0;
    assign bus.cdb_data = bus.cdb_en ? data_q[head_q] : '0;
    assign bus.overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.rdy) begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (bus.in_en && !bus.in_ready) overflow_q <= 1'b1;
        end
    end

    // NOTE: payload storage has no reset; valid_q alone decides whether a slot means anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clear) btag_q[i] <= btag_q[i] & ~br_bit;
        end
        if (push) begin
            data_q[tail_q] <= result;
            tag_q[tail_q]  <= bus.in_tag;
            btag_q[tail_q] <= in_btag_eff;
        end
    end
endmodule

// File: tb/tb_alu_exec_wb.sv
// Directed bench for alu_exec_wb: op vector table plus hand-written sequences
// for backpressure, squash, branch free, rdy freeze and mid-run reset.
module tb_alu_exec_wb;
    import alu_exec_wb_pkg::*;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int BTAG_W = 4;
    localparam int OP_W   = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_wb_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .BTAG_W(BTAG_W), .OP_W(OP_W)) bus ();

    alu_exec_wb #(.DATA_W(DATA_W), .TAG_W(TAG_W), .BTAG_W(BTAG_W), .OP_W(OP_W), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_en      = 1'b0;
        bus.in_op_a    = '0;
        bus.in_op_b    = '0;
        bus.in_op      = '0;
        bus.in_tag     = '0;
        bus.in_pc      = '0;
        bus.in_btag    = '0;
        bus.b_free_en  = 1'b0;
        bus.b_free_num = '0;
        bus.mis_taken  = 1'b0;
    endtask

    task automatic issue(input logic [5:0] tag, input logic [3:0] btag, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        idle();
        bus.in_en   = 1'b1;
        bus.in_tag  = tag;
        bus.in_btag = btag;
        bus.in_op   = op;
        bus.in_op_a = a;
        bus.in_op_b = b;
        bus.in_pc   = pc;
    endtask

    // Grant must already be high; waits a bounded number of cycles, then consumes the broadcast.
    task automatic wait_bcast(input string name, input logic [5:0] etag, input logic [31:0] edata);
        int n = 0;
        while (!bus.cdb_en && n < 8) begin
            tick();
            n++;
        end
        check({name, "_en"}, bus.cdb_en, 1);
        check({name, "_tag"}, bus.cdb_tag, etag);
        check({name, "_data"}, bus.cdb_data, edata);
        tick();
    endtask

    task automatic no_bcast(input string name, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            seen |= bus.cdb_req | bus.cdb_en;
            tick();
        end
        check(name, seen, 0);
    endtask

    initial begin
        vecs[0]  = '{"add",      OP_ADD,   32'd5,          32'd7,          32'h0,          32'd12};
        vecs[1]  = '{"add_wrap", OP_ADD,   32'hFFFF_FFFF,  32'd1,          32'h0,          32'h0};
        vecs[2]  = '{"sub",      OP_SUB,   32'd5,          32'd7,          32'h0,          32'hFFFF_FFFE};
        vecs[3]  = '{"sll",      OP_SLL,   32'd1,          32'd35,         32'h0,          32'd8};
        vecs[4]  = '{"srl",      OP_SRL,   32'h8000_0000,  32'd4,          32'h0,          32'h0800_0000};
        vecs[5]  = '{"sra",      OP_SRA,   32'h8000_0000,  32'd4,          32'h0,          32'hF800_0000};
        vecs[6]  = '{"slt",      OP_SLT,   32'd1,          32'hFFFF_FFFF,  32'h0,          32'd0};
        vecs[7]  = '{"sltu",     OP_SLTU,  32'd1,          32'hFFFF_FFFF,  32'h0,          32'd1};
        vecs[8]  = '{"xor",      OP_XOR,   32'h0000_F0F0,  32'h0000_FF00,  32'h0,          32'h0000_0FF0};
        vecs[9]  = '{"or",       OP_OR,    32'h0000_F0F0,  32'h0000_0F00,  32'h0,          32'h0000_FFF0};
        vecs[10] = '{"and",      OP_AND,   32'h0000_F0F0,  32'h0000_FF00,  32'h0,          32'h0000_F000};
        vecs[11] = '{"lui",      OP_LUI,   32'd9,          32'h1234_5000,  32'h0,          32'h1234_5000};
        vecs[12] = '{"auipc",    OP_AUIPC, 32'd9,          32'h0000_1000,  32'h100,        32'h0000_1100};
        vecs[13] = '{"jal",      OP_JAL,   32'd9,          32'd9,          32'h100,        32'h104};
        vecs[14] = '{"jalr",     OP_JALR,  32'd9,          32'd9,          32'hFFFF_FFFC,  32'h0};
        vecs[15] = '{"unknown",  6'h3F,    32'd5,          32'd7,          32'h100,        32'h0};

        rst           = 1'b1;
        bus.rdy       = 1'b1;
        bus.cdb_grant = 1'b0;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_cdb_req", bus.cdb_req, 0);
        check("rst_cdb_en", bus.cdb_en, 0);
        check("rst_cdb_tag", bus.cdb_tag, 0);
        check("rst_cdb_data", bus.cdb_data, 0);
        check("rst_overflow", bus.overflow, 0);

        // Op table: issue with grant high, broadcast one cycle later, queue empty after.
        bus.cdb_grant = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(6'(i + 16), 4'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc);
            #1;
            if (i == 0) check("no_bypass_req", bus.cdb_req, 0);
            tick();
            idle();
            check({vecs[i].name, "_en"}, bus.cdb_en, 1);
            check({vecs[i].name, "_tag"}, bus.cdb_tag, 6'(i + 16));
            check({vecs[i].name, "_data"}, bus.cdb_data, vecs[i].exp);
            tick();
            check({vecs[i].name, "_drained"}, bus.cdb_req, 0);
        end

        issue(6'd0, 4'b0, OP_ADD, 32'd1, 32'd1, 32'h0);
        tick();
        idle();
        no_bcast("tag_free_skipped", 3);

        // Backpressure and overflow.
        bus.cdb_grant = 1'b0;
        issue(6'd1, 4'b0, OP_ADD, 32'd10, 32'd1, 32'h0);
        tick();
        issue(6'd2, 4'b0, OP_ADD, 32'd20, 32'd2, 32'h0);
        tick();
        idle();
        check("full_in_ready", bus.in_ready, 0);
        check("full_req_no_grant", bus.cdb_req, 1);
        check("full_en_no_grant", bus.cdb_en, 0);
        issue(6'd5, 4'b0, OP_ADD, 32'd50, 32'd0, 32'h0);
        tick();
        idle();
        check("overflow_set", bus.overflow, 1);
        bus.cdb_grant = 1'b1;
        #1;
        wait_bcast("bp_first", 6'd1, 32'd11);
        check("bp_second_en", bus.cdb_en, 1);
        check("bp_second_tag", bus.cdb_tag, 6'd2);
        check("bp_second_data", bus.cdb_data, 32'd22);
        tick();
        no_bcast("bp_dropped", 3);
        check("bp_in_ready", bus.in_ready, 1);

        // Mispredict squashes the queued head; survivor still broadcasts.
        bus.cdb_grant = 1'b0;
        issue(6'd3, 4'b0010, OP_ADD, 32'd3, 32'd0, 32'h0);
        tick();
        issue(6'd4, 4'b0000, OP_ADD, 32'd4, 32'd0, 32'h0);
        tick();
        idle();
        check("sq_full", bus.in_ready, 0);
        bus.cdb_grant  = 1'b1;
        bus.b_free_en  = 1'b1;
        bus.mis_taken  = 1'b1;
        bus.b_free_num = 2'd1;
        #1;
        check("sq_head_req_same_cycle", bus.cdb_req, 0);
        check("sq_head_en_same_cycle", bus.cdb_en, 0);
        tick();
        idle();
        wait_bcast("sq_survivor", 6'd4, 32'd4);
        no_bcast("sq_after_survivor", 3);

        // Incoming issue squashed by a mispredict in the same cycle.
        issue(6'd9, 4'b0010, OP_ADD, 32'd9, 32'd0, 32'h0);
        bus.b_free_en  = 1'b1;
        bus.mis_taken  = 1'b1;
        bus.b_free_num = 2'd1;
        tick();
        idle();
        no_bcast("sq_incoming", 4);

        // Branch free clears bit 0; mispredict on 0 spares it, on 2 kills it.
        bus.cdb_grant = 1'b0;
        issue(6'd6, 4'b0101, OP_ADD, 32'd6, 32'd0, 32'h0);
        tick();
        idle();
        bus.b_free_en  = 1'b1;
        bus.b_free_num = 2'd0;
        tick();
        idle();
        bus.b_free_en  = 1'b1;
        bus.mis_taken  = 1'b1;
        bus.b_free_num = 2'd0;
        tick();
        idle();
        check("bf_survives_num0", bus.cdb_req, 1);
        bus.b_free_en  = 1'b1;
        bus.mis_taken  = 1'b1;
        bus.b_free_num = 2'd2;
        #1;
        check("bf_kill_num2_req", bus.cdb_req, 0);
        tick();
        idle();
        bus.cdb_grant = 1'b1;
        no_bcast("bf_killed", 3);

        // rdy low freezes a full queue.
        bus.cdb_grant = 1'b0;
        issue(6'd7, 4'b0, OP_ADD, 32'd3, 32'd4, 32'h0);
        tick();
        issue(6'd8, 4'b0, OP_ADD, 32'd8, 32'd0, 32'h0);
        tick();
        idle();
        bus.rdy       = 1'b0;
        bus.cdb_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rdy_low_req", bus.cdb_req, 0);
            check("rdy_low_en", bus.cdb_en, 0);
            tick();
        end
        bus.rdy = 1'b1;
        #1;
        check("rdy_held_full", bus.in_ready, 0);
        wait_bcast("rdy_first", 6'd7, 32'd7);
        wait_bcast("rdy_second", 6'd8, 32'd8);

        // Reset mid-operation with an entry queued and overflow sticky.
        bus.cdb_grant = 1'b0;
        issue(6'd11, 4'b0, OP_ADD, 32'd11, 32'd0, 32'h0);
        tick();
        idle();
        check("pre_rst_req", bus.cdb_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_overflow", bus.overflow, 0);
        check("mid_rst_req", bus.cdb_req, 0);
        bus.cdb_grant = 1'b1;
        no_bcast("mid_rst_empty", 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_wb.md
Name: alu_exec_wb

Overview:
Execution and writeback stage directly downstream of the ALU reservation station. It accepts one issued ALU instruction per cycle and computes the result into a registered result queue. It then requests the common data bus (CDB), broadcasting tag/data on grant. Queued results track branch-tag dependencies, so a misprediction squashes speculative results before they reach the CDB.

Parameters:
DATA_W, 32, operand/result width
TAG_W, 6, rename tag width; 0 = tagFree
BTAG_W, 4, branch-tag bitmask width
OP_W, 6, opcode width (encodings from defines.v)
DEPTH, 2, result queue entries (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze all state
in_en  in  1  issue valid from ALU RS
in_op_a  in  DATA_W  operand 1
in_op_b  in  DATA_W  operand 2 (imm already substituted)
in_op  in  OP_W  opcode
in_tag  in  TAG_W  destination tag
in_pc  in  DATA_W  instruction address
in_btag  in  BTAG_W  branch dependency mask
in_ready  out  1  queue can accept this cycle
b_free_en  in  1  branch resolved
b_free_num  in  2  index of resolved branch
mis_taken  in  1  resolved branch mispredicted
cdb_req  out  1  head entry valid, requesting CDB
cdb_grant  in  1  arbiter grant for this cycle
cdb_en  out  1  broadcast valid
cdb_tag  out  TAG_W  broadcast tag
cdb_data  out  DATA_W  broadcast data
overflow  out  1  sticky: in_en seen while in_ready low

Behaviour:
- Reset: queue empty, count=0, head=tail=0, overflow=0. Outputs: cdb_req=0, cdb_en=0, cdb_tag=0, cdb_data=0, in_ready=1.
- Compute (combinational from in_*): ADD a+b; SUB a-b; SLL a<<b[4:0]; SRL logical; SRA arithmetic; SLT signed; SLTU unsigned (result 1/0); XOR/OR/AND; LUI b; AUIPC pc+b; JAL/JALR pc+4; unknown op -> 0. Results are mod 2^DATA_W.
- Push: at posedge with rdy & in_en & in_ready, write {result, in_tag, btag'} at tail. Skip the push when in_tag==0 or when squashed (below).
- Latency: issue in cycle N -> cdb_req high in cycle N+1 at the earliest. There is no bypass.
- in_ready = (count < DEPTH), computed from the current count only. A simultaneous pop does not free space the same cycle.
- in_en while !in_ready: input dropped, overflow set until rst.
- Output: cdb_req = rdy & head valid. cdb_en = cdb_req & cdb_grant (combinational). cdb_tag/cdb_data = head fields when cdb_en, else 0.
- Pop: at posedge with cdb_en, advance head. Push and pop in the same cycle leaves count unchanged.
- Branch free (b_free_en & !mis_taken): clear bit b_free_num in every valid entry's mask and in the incoming btag'.
- Mispredict (b_free_en & mis_taken):
  - Invalidate every valid entry whose mask has bit b_free_num set.
  - Suppress the incoming push if in_btag has that bit set.
  - Invalidated entries are removed from the queue, and remaining entries keep program order; compaction or per-entry valid bits with head skipping are both acceptable.
  - A squashed head must not raise cdb_req that cycle or later. The squash takes precedence over a grant in the same cycle.
- rdy low: no push, no pop, no mask update. cdb_req=0, cdb_en=0, overflow unchanged.
- Head/tail pointers wrap modulo DEPTH.

Test Plan:
- Basic ADD: in_en, a=5, b=7, tag=0x11, btag=0 at cycle 0, grant held high -> cycle 1: cdb_en=1, tag=0x11, data=12; cycle 2: cdb_req=0.
- Op coverage: SRA a=0x80000000, b=4 -> 0xF8000000. SLTU a=1, b=0xFFFFFFFF -> 1. SLT same operands -> 0. JAL pc=0x100 -> 0x104. AUIPC pc=0x100, b=0x1000 -> 0x1100.
- Backpressure: grant low, issue tags 1 and 2 -> in_ready=0. Third in_en -> overflow=1, entry dropped. Grant high -> tags 1 then 2 broadcast on consecutive cycles, in order.
- Mispredict squash:
  - Queue holds tag 3 (btag 0b0010) and tag 4 (btag 0), grant low.
  - Pulse b_free_en=1, mis_taken=1, num=1 -> tag 3 vanishes.
  - Grant high -> only tag 4 is broadcast.
  - An issue the same cycle with btag 0b0010 is never broadcast.
- Branch free: entry btag 0b0101, b_free_en=1, mis_taken=0, num=0 -> mask becomes 0b0100. A later mispredict with num=0 leaves the entry intact; one with num=2 squashes it.
- rdy/reset: with the queue full, rdy=0 for 3 cycles -> no cdb_en, state held. rst mid-operation -> count=0, in_ready=1, overflow=0, cdb_req=0 next cycle.
